// File: rtl/scoreboard_pkg.sv
// Shared types and one-hot helpers for the register write scoreboard.
package scoreboard_pkg;

  localparam int NUM_REGS = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sb_state_e;

  typedef logic [NUM_REGS-1:0] onehot16_t;

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic multi_hot(input onehot16_t v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

  function automatic logic exactly_one_hot(input onehot16_t v);
    return (v != 16'd0) && !multi_hot(v);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// One outstanding-write counter: saturating increment, floor-at-zero decrement,
// with a registered non-zero flag that feeds the busy vector.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             busy,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             busy_r;
  logic             inc_eff_s;
  logic             dec_eff_s;

  // Next count; a coincident inc and dec cancel, and the guards keep the count from wrapping.
  always_comb begin
    cnt_nxt_s = cnt_r;
    dec_eff_s = dec & (cnt_r != CNT_ZERO);
    inc_eff_s = inc & ((cnt_r != CNT_MAX) | dec_eff_s);
    if (inc_eff_s && !dec_eff_s) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (dec_eff_s && !inc_eff_s) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count and non-zero flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= CNT_ZERO;
      busy_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      busy_r <= (cnt_nxt_s != CNT_ZERO);
    end
  end

  assign cnt_nxt = cnt_nxt_s;
  assign busy    = busy_r;
  assign at_max  = (cnt_r == CNT_MAX);

endmodule

// File: rtl/reg_scoreboard.sv
// Read-after-write scoreboard for the 16-entry register file, with drain sequencing.
// Optional one-hot protocol checking is enabled by defining SCOREBOARD_ONEHOT_CHECK_EN.
module reg_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [15:0]      issue_dest,
  input  logic [15:0]      issue_src_a,
  input  logic [15:0]      issue_src_b,
  input  logic             wb_valid,
  input  logic [15:0]      wb_dest,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [15:0]      busy,
  output logic [CNT_W+3:0] inflight,
  output logic             err
);

  onehot16_t        inc_s;
  onehot16_t        dec_s;
  onehot16_t        busy_s;
  onehot16_t        max_s;
  logic [CNT_W-1:0] cnt_nxt_s [NUM_REGS];
  logic [CNT_W+3:0] inflight_r;
  logic [CNT_W+3:0] inflight_nxt_s;
  sb_state_e        state_r;
  sb_state_e        state_nxt_s;
  logic             drain_done_r;
  logic             hazard_s;
  logic             sat_s;
  logic             ready_s;
  logic             accept_s;

  // Hazard and saturation look only at registered counter state, so writebacks never bypass.
  assign hazard_s = |((issue_src_a | issue_src_b) & busy_s);
  assign sat_s    = |(issue_dest & max_s);
  assign ready_s  = rst_n & (state_r == RUN) & ~hazard_s & ~sat_s;
  assign accept_s = issue_valid & ready_s;
  assign inc_s    = accept_s ? issue_dest : 16'h0000;
  assign dec_s    = wb_valid ? wb_dest : 16'h0000;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc_s[gi]),
      .dec     (dec_s[gi]),
      .cnt_nxt (cnt_nxt_s[gi]),
      .busy    (busy_s[gi]),
      .at_max  (max_s[gi])
    );
  end

  // Sum of next counter values so inflight updates on the same edge as the counters.
  always_comb begin
    inflight_nxt_s = {(CNT_W+4){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      inflight_nxt_s = inflight_nxt_s + (CNT_W+4)'(cnt_nxt_s[i]);
    end
  end

  // Drain state machine: next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (drain_req) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (inflight_r == {(CNT_W+4){1'b0}}) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE:    state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // State, inflight total and the registered drain-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RUN;
      inflight_r   <= {(CNT_W+4){1'b0}};
      drain_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      inflight_r   <= inflight_nxt_s;
      drain_done_r <= (state_nxt_s == DONE);
    end
  end

`ifdef SCOREBOARD_ONEHOT_CHECK_EN
  logic err_r;
  logic err_set_s;

  assign err_set_s = (accept_s & (multi_hot(issue_dest) | multi_hot(issue_src_a) |
                                  multi_hot(issue_src_b)))
                   | (wb_valid & (~exactly_one_hot(wb_dest) | (|(wb_dest & ~busy_s))));

  // Sticky protocol error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign issue_ready = ready_s;
  assign drain_done  = drain_done_r;
  assign busy        = busy_s;
  assign inflight    = inflight_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, drain/reset/error
// sequences, and randomized traffic checked against a per-register count model.
module tb_reg_scoreboard;

  localparam int CNT_W = 2;
  localparam int CMAX  = 3;
`ifdef SCOREBOARD_ONEHOT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid;
  logic             issue_ready;
  logic [15:0]      issue_dest;
  logic [15:0]      issue_src_a;
  logic [15:0]      issue_src_b;
  logic             wb_valid;
  logic [15:0]      wb_dest;
  logic             drain_req;
  logic             drain_done;
  logic [15:0]      busy;
  logic [CNT_W+3:0] inflight;
  logic             err;

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_dest  (issue_dest),
    .issue_src_a (issue_src_a),
    .issue_src_b (issue_src_b),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .busy        (busy),
    .inflight    (inflight),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_m [16];
  bit err_m;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [15:0] sa;
    logic [15:0] sb;
    logic        wv;
    logic [15:0] wd;
    logic        rdy;
    logic [15:0] bsy;
    int          infl;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] d, input logic [15:0] sa,
                        input logic [15:0] sb, input logic wv, input logic [15:0] wd);
    issue_valid = v;
    issue_dest  = d;
    issue_src_a = sa;
    issue_src_b = sb;
    wb_valid    = wv;
    wb_dest     = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drain_req = 1'b0;
    set_in(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 16; i++) cnt_m[i] = 0;
    err_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_inflight", 32'(inflight), 32'h0);
    check("rst_ready", 32'(issue_ready), 32'h0);
    check("rst_done", 32'(drain_done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Reference: an issue may go when no source is outstanding and no destination is full.
  function automatic bit m_ready(input logic [15:0] d, input logic [15:0] sa, input logic [15:0] sb);
    for (int i = 0; i < 16; i++) begin
      if ((sa[i] || sb[i]) && cnt_m[i] > 0) return 1'b0;
      if (d[i] && cnt_m[i] == CMAX) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_update(input logic v, input logic [15:0] d, input logic [15:0] sa,
                          input logic [15:0] sb, input logic wv, input logic [15:0] wd);
    bit acc;
    acc = v && m_ready(d, sa, sb);
    if (acc && ($countones(d) > 1 || $countones(sa) > 1 || $countones(sb) > 1)) err_m = 1'b1;
    if (wv && $countones(wd) != 1) err_m = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (wv && wd[i] && cnt_m[i] == 0) err_m = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      int delta;
      delta = 0;
      if (acc && d[i]) delta = delta + 1;
      if (wv && wd[i] && cnt_m[i] > 0) delta = delta - 1;
      cnt_m[i] = cnt_m[i] + delta;
    end
  endtask

  function automatic logic [15:0] m_busy();
    logic [15:0] b;
    b = 16'h0;
    for (int i = 0; i < 16; i++) b[i] = (cnt_m[i] > 0);
    return b;
  endfunction

  function automatic int m_inflight();
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += cnt_m[i];
    return s;
  endfunction

  function automatic logic [15:0] rnd_onehot();
    logic [15:0] one;
    one = 16'h0001;
    return one << $urandom_range(0, 15);
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 16'h0008, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0008, 1};
    tbl[1]  = '{1'b1, 16'h0000, 16'h0008, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0008, 1};
    tbl[2]  = '{1'b0, 16'h0000, 16'h0008, 16'h0000, 1'b1, 16'h0008, 1'b0, 16'h0000, 0};
    tbl[3]  = '{1'b1, 16'h0000, 16'h0008, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 0};
    tbl[4]  = '{1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001, 1};
    tbl[5]  = '{1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001, 2};
    tbl[6]  = '{1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001, 3};
    tbl[7]  = '{1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0001, 3};
    tbl[8]  = '{1'b1, 16'h0010, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0011, 4};
    tbl[9]  = '{1'b1, 16'h0010, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b1, 16'h0011, 4};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h0011, 3};
    tbl[11] = '{1'b1, 16'h0000, 16'h0000, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0011, 3};
    tbl[12] = '{1'b1, 16'h0002, 16'h0001, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0001, 2};
    tbl[13] = '{1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001, 3};

    do_reset();

    // Directed vectors: ready before the edge, busy/inflight after it.
    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].v, tbl[i].d, tbl[i].sa, tbl[i].sb, tbl[i].wv, tbl[i].wd);
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(issue_ready), 32'(tbl[i].rdy));
      tick();
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("tbl%0d_inflight", i), 32'(inflight), 32'(tbl[i].infl));
    end

    // Drain with two registers outstanding, one writeback per cycle.
    do_reset();
    set_in(1'b1, 16'h0002, 16'h0, 16'h0, 1'b0, 16'h0); tick();
    set_in(1'b1, 16'h0004, 16'h0, 16'h0, 1'b0, 16'h0); tick();
    set_in(1'b0, 16'h0000, 16'h0, 16'h0, 1'b0, 16'h0);
    drain_req = 1'b1;
    #1;
    check("drn_ready_run", 32'(issue_ready), 32'h1);
    tick();
    drain_req = 1'b0;
    check("drn_done0", 32'(drain_done), 32'h0);
    set_in(1'b1, 16'h0000, 16'h0, 16'h0, 1'b1, 16'h0002);
    #1;
    check("drn_ready1", 32'(issue_ready), 32'h0);
    tick();
    check("drn_inflight1", 32'(inflight), 32'h1);
    check("drn_done1", 32'(drain_done), 32'h0);
    set_in(1'b1, 16'h0000, 16'h0, 16'h0, 1'b1, 16'h0004);
    drain_req = 1'b1;
    #1;
    check("drn_ready2", 32'(issue_ready), 32'h0);
    tick();
    drain_req = 1'b0;
    check("drn_inflight0", 32'(inflight), 32'h0);
    check("drn_done2", 32'(drain_done), 32'h0);
    set_in(1'b1, 16'h0000, 16'h0, 16'h0, 1'b0, 16'h0);
    #1;
    check("drn_ready3", 32'(issue_ready), 32'h0);
    tick();
    check("drn_done_pulse", 32'(drain_done), 32'h1);
    check("drn_ready_done", 32'(issue_ready), 32'h0);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    check("drn_done_end", 32'(drain_done), 32'h0);
    check("drn_ready_back", 32'(issue_ready), 32'h1);
    tick();
    check("drn_ignored_in_done", 32'(drain_done), 32'h0);
    check("drn_still_run", 32'(issue_ready), 32'h1);

    // Drain with nothing outstanding still takes two cycles.
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    check("edrn_done0", 32'(drain_done), 32'h0);
    check("edrn_ready0", 32'(issue_ready), 32'h0);
    tick();
    check("edrn_done1", 32'(drain_done), 32'h1);
    tick();
    check("edrn_done2", 32'(drain_done), 32'h0);
    check("edrn_ready2", 32'(issue_ready), 32'h1);

    // Reset in the middle of a drain.
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, (i < 3) ? 16'h0001 : 16'h0002, 16'h0, 16'h0, 1'b0, 16'h0);
      tick();
    end
    set_in(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);
    check("rdrn_inflight5", 32'(inflight), 32'h5);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    check("rdrn_in_drain", 32'(issue_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rdrn_busy", 32'(busy), 32'h0);
    check("rdrn_inflight", 32'(inflight), 32'h0);
    check("rdrn_ready", 32'(issue_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rdrn_no_pulse", 32'(drain_done), 32'h0);
    end
    check("rdrn_run", 32'(issue_ready), 32'h1);

    // Multi-hot writeback.
    do_reset();
    set_in(1'b1, 16'h0001, 16'h0, 16'h0, 1'b0, 16'h0); tick();
    set_in(1'b1, 16'h0002, 16'h0, 16'h0, 1'b0, 16'h0); tick();
    set_in(1'b0, 16'h0000, 16'h0, 16'h0, 1'b1, 16'h0003); tick();
    check("mh_err", 32'(err), 32'(CHK));
    check("mh_busy", 32'(busy), 32'h0);
    check("mh_inflight", 32'(inflight), 32'h0);
    set_in(1'b0, 16'h0000, 16'h0, 16'h0, 1'b0, 16'h0);
    repeat (2) tick();
    check("mh_err_sticky", 32'(err), 32'(CHK));

    // Randomized traffic against the count model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic v, wv;
      logic [15:0] d, sa, sb, wd;
      int r;
      v  = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      d  = (r < 2) ? 16'h0 : ((r == 9) ? (rnd_onehot() | rnd_onehot()) : rnd_onehot());
      sa = ($urandom_range(0, 1) == 0) ? 16'h0 : rnd_onehot();
      sb = ($urandom_range(0, 2) == 0) ? rnd_onehot() : 16'h0;
      wv = ($urandom_range(0, 2) != 0);
      wd = ($urandom_range(0, 9) == 0) ? (rnd_onehot() | rnd_onehot()) : rnd_onehot();
      set_in(v, d, sa, sb, wv, wd);
      #1;
      check("rnd_ready", 32'(issue_ready), 32'(m_ready(d, sa, sb)));
      m_update(v, d, sa, sb, wv, wd);
      tick();
      check("rnd_busy", 32'(busy), 32'(m_busy()));
      check("rnd_inflight", 32'(inflight), 32'(m_inflight()));
      check("rnd_err", 32'(err), 32'(CHK & err_m));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
